vid_seq_gen: RTL and testbench

Multi-beat vector index sequence generator for the vALU: the parametrised successor of the single-beat vid unit. One accepted request (start index, vl, SEW, base destination address) is expanded into the full run of index beats for `vid.v`. Each beat is masked past vl, the destination address advances by one per beat, and a stallable output pipeline honours ready/valid backpressure. It sits beside the other vALU functional units and feeds the shared writeback arbiter.

---
 rtl/vid_pkg.sv | 34 +++
 rtl/vid_seq_gen_if.sv | 48 ++++
 rtl/vid_pipe_stage.sv | 52 +++++
 rtl/vid_seq_gen.sv | 202 ++++++++++++++++++++
 tb/tb_vid_seq_gen.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vid_pkg.sv
// vid_pkg: shared types and helpers for the vid.v index sequence generator.
//   sew_e          : element-width encoding (0=8b, 1=16b, 2=32b, 3=64b)
//   NUM_SEWS       : number of SEW encodings
//   MAX_LANES      : widest byte-lane vector the helpers support (DATA_WIDTH <= 2048)
//   elems_per_beat : elements carried by one beat for a given SEW and beat width
//   be_for_sew     : expands a per-element body mask into per-byte enables
package vid_pkg;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_e;

  localparam int unsigned NUM_SEWS  = 4;
  localparam int unsigned MAX_LANES = 256;

  function automatic int unsigned elems_per_beat(sew_e sew, int unsigned data_width);
    return data_width / (32'd8 << sew);
  endfunction

  // Byte j belongs to element j >> sew, so it inherits that element's body bit.
  function automatic logic [MAX_LANES-1:0] be_for_sew(logic [MAX_LANES-1:0] elem_mask,
                                                      sew_e sew);
    logic [MAX_LANES-1:0] be;
    be = '0;
    for (int unsigned j = 0; j < MAX_LANES; j++) begin
      be[8'(j)] = elem_mask[8'(j >> sew)];
    end
    return be;
  endfunction

endpackage

// File: rtl/vid_seq_gen_if.sv
// vid_seq_gen_if: request and beat-output bundle of the vid.v sequence generator.
//   request : in_valid/in_ready handshake, in_sew, in_start_idx, in_vl, in_addr
//   output  : out_valid/out_ready handshake, out_vec, out_be, out_addr, out_last
//   status  : err_sew
//   VID_STRIDE_EN defined adds in_base/in_stride (64b each).
// Modports: slave = generator side, master = requester/consumer side.
interface vid_seq_gen_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned SEW_WIDTH  = 2,
  parameter int unsigned VL_WIDTH   = 12
);

  logic                    in_valid;
  logic                    in_ready;
  logic [SEW_WIDTH-1:0]    in_sew;
  logic [VL_WIDTH-1:0]     in_start_idx;
  logic [VL_WIDTH-1:0]     in_vl;
  logic [ADDR_WIDTH-1:0]   in_addr;
`ifdef VID_STRIDE_EN
  logic [63:0]             in_base;
  logic [63:0]             in_stride;
`endif
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_vec;
  logic [DATA_WIDTH/8-1:0] out_be;
  logic [ADDR_WIDTH-1:0]   out_addr;
  logic                    out_last;
  logic                    err_sew;

  modport slave (
`ifdef VID_STRIDE_EN
    input  in_base, in_stride,
`endif
    input  in_valid, in_sew, in_start_idx, in_vl, in_addr, out_ready,
    output in_ready, out_valid, out_vec, out_be, out_addr, out_last, err_sew
  );

  modport master (
`ifdef VID_STRIDE_EN
    output in_base, in_stride,
`endif
    output in_valid, in_sew, in_start_idx, in_vl, in_addr, out_ready,
    input  in_ready, out_valid, out_vec, out_be, out_addr, out_last, err_sew
  );

endinterface

// File: rtl/vid_pipe_stage.sv
// vid_pipe_stage: one stallable output register stage of the vid.v generator.
//   clk, rst : clock, asynchronous active-high reset (clears every field)
//   adv_i    : pipeline advance; low freezes the stage
//   *_i/*_o  : valid, vec, be, addr, last in and registered out
module vid_pipe_stage #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    adv_i,
  input  logic                    valid_i,
  input  logic [DATA_WIDTH-1:0]   vec_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    last_i,
  output logic                    valid_o,
  output logic [DATA_WIDTH-1:0]   vec_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic                    last_o
);

  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   vec_q;
  logic [DATA_WIDTH/8-1:0] be_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      vec_q   <= '0;
      be_q    <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
    end else if (adv_i) begin
      valid_q <= valid_i;
      vec_q   <= vec_i;
      be_q    <= be_i;
      addr_q  <= addr_i;
      last_q  <= last_i;
    end
  end

  assign valid_o = valid_q;
  assign vec_o   = vec_q;
  assign be_o    = be_q;
  assign addr_o  = addr_q;
  assign last_o  = last_q;

endmodule

// File: rtl/vid_seq_gen.sv
// vid_seq_gen: expands one request (start, vl, SEW, base address) into the full
// run of vid.v index beats, masked past vl, through OUT_STAGES stallable stages.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : vid_seq_gen_if.slave (request handshake, beat output, err_sew)
// Build option: VID_STRIDE_EN defined -> element = in_base + index * in_stride;
// otherwise element = index.
//
// state   | meaning
// IDLE    | in_ready high; waiting for a request
// RUN     | emitting one beat per advancing cycle until the last beat issues
module vid_seq_gen
  import vid_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned SEW_WIDTH     = 2,
  parameter int unsigned VL_WIDTH      = 12,
  parameter bit          ENABLE_64_BIT = 1'b1,
  parameter int unsigned OUT_STAGES    = 2
) (
  input  logic          clk,
  input  logic          rst,
  vid_seq_gen_if.slave  bus
);

  localparam int unsigned NB = DATA_WIDTH / 8;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e                state_q, state_d;
  sew_e                  sew_q, sew_d;
  logic [VL_WIDTH-1:0]   idx_q, idx_d;
  logic [VL_WIDTH-1:0]   vl_q, vl_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  err_q, err_d;
`ifdef VID_STRIDE_EN
  logic [63:0]           base_q, base_d;
  logic [63:0]           stride_q, stride_d;
`endif

  logic                  adv;
  logic                  sew_ok;
  logic                  has_beats;
  logic                  last_beat;
  logic [VL_WIDTH:0]     next_idx;
  logic [DATA_WIDTH-1:0] gen_vec;
  logic [NB-1:0]         gen_be;

  logic [OUT_STAGES:0]   st_valid;
  logic [OUT_STAGES:0]   st_last;
  logic [DATA_WIDTH-1:0] st_vec  [OUT_STAGES+1];
  logic [NB-1:0]         st_be   [OUT_STAGES+1];
  logic [ADDR_WIDTH-1:0] st_addr [OUT_STAGES+1];

  // A stalled output freezes the whole chain and the generator with it.
  assign adv       = !(st_valid[OUT_STAGES] && !bus.out_ready);
  assign sew_ok    = !(sew_e'(bus.in_sew) == SEW_64 && !ENABLE_64_BIT);
  assign has_beats = bus.in_start_idx < bus.in_vl;
  // idx_q is the index of the beat's first element; the beat is last once the
  // next beat's first element would already be tail.
  assign next_idx  = {1'b0, idx_q} + (VL_WIDTH+1)'(elems_per_beat(sew_q, DATA_WIDTH));
  assign last_beat = next_idx >= {1'b0, vl_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sew_q    <= SEW_8;
      idx_q    <= '0;
      vl_q     <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
`ifdef VID_STRIDE_EN
      base_q   <= '0;
      stride_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sew_q    <= sew_d;
      idx_q    <= idx_d;
      vl_q     <= vl_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
`ifdef VID_STRIDE_EN
      base_q   <= base_d;
      stride_q <= stride_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    sew_d    = sew_q;
    idx_d    = idx_q;
    vl_d     = vl_q;
    addr_d   = addr_q;
    err_d    = 1'b0;
`ifdef VID_STRIDE_EN
    base_d   = base_q;
    stride_d = stride_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          // Empty and illegal requests are consumed here without a beat.
          if (!sew_ok) begin
            err_d = 1'b1;
          end else if (has_beats) begin
            state_d  = ST_RUN;
            sew_d    = sew_e'(bus.in_sew);
            idx_d    = bus.in_start_idx;
            vl_d     = bus.in_vl;
            addr_d   = bus.in_addr;
`ifdef VID_STRIDE_EN
            base_d   = bus.in_base;
            stride_d = bus.in_stride;
`endif
          end
        end
      end
      ST_RUN: begin
        if (adv) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (last_beat) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = next_idx[VL_WIDTH-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte-lane generator: byte j is byte (j mod element bytes) of element j >> sew.
  always_comb begin : p_gen
    int unsigned          k;
    int unsigned          bpos;
    logic [63:0]          eidx;
    logic [63:0]          val;
    logic [MAX_LANES-1:0] elem_mask;
    logic [DATA_WIDTH-1:0] raw_vec;
    k         = 0;
    bpos      = 0;
    eidx      = '0;
    val       = '0;
    elem_mask = '0;
    raw_vec   = '0;
    gen_vec   = '0;
    for (int unsigned j = 0; j < NB; j++) begin
      k    = j >> sew_q;
      bpos = j & ((32'd1 << sew_q) - 32'd1);
      eidx = 64'(idx_q) + 64'(k);
`ifdef VID_STRIDE_EN
      val  = base_q + eidx * stride_q;
`else
      val  = eidx;
`endif
      elem_mask[8'(k)]  = eidx < 64'(vl_q);
      raw_vec[j*8 +: 8] = val[bpos*8 +: 8];
    end
    gen_be = NB'(be_for_sew(elem_mask, sew_q));
    for (int unsigned j = 0; j < NB; j++) begin
      gen_vec[j*8 +: 8] = gen_be[j] ? raw_vec[j*8 +: 8] : 8'h00;
    end
  end

  assign st_valid[0] = (state_q == ST_RUN);
  assign st_vec[0]   = gen_vec;
  assign st_be[0]    = gen_be;
  assign st_addr[0]  = addr_q;
  assign st_last[0]  = last_beat;

  for (genvar s = 0; s < OUT_STAGES; s++) begin : g_stage
    vid_pipe_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .adv_i   (adv),
      .valid_i (st_valid[s]),
      .vec_i   (st_vec[s]),
      .be_i    (st_be[s]),
      .addr_i  (st_addr[s]),
      .last_i  (st_last[s]),
      .valid_o (st_valid[s+1]),
      .vec_o   (st_vec[s+1]),
      .be_o    (st_be[s+1]),
      .addr_o  (st_addr[s+1]),
      .last_o  (st_last[s+1])
    );
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.err_sew   = err_q;
  assign bus.out_valid = st_valid[OUT_STAGES];
  assign bus.out_vec   = st_vec[OUT_STAGES];
  assign bus.out_be    = st_be[OUT_STAGES];
  assign bus.out_addr  = st_addr[OUT_STAGES];
  assign bus.out_last  = st_last[OUT_STAGES];

endmodule

// File: tb/tb_vid_seq_gen.sv
// tb_vid_seq_gen: scoreboard bench for vid_seq_gen (64-bit beats, 64-bit SEW disabled).
module tb_vid_seq_gen;

  localparam int unsigned DW     = 64;
  localparam int unsigned AW     = 5;
  localparam int unsigned VLW    = 12;
  localparam bit          EN64   = 1'b0;
  localparam int unsigned STAGES = 2;

  typedef struct packed {
    logic [63:0] vec;
    logic [7:0]  be;
    logic [4:0]  addr;
    logic        last;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  bit    rand_ready = 1'b0;
  bit    held_v = 1'b0;
  beat_t held;

  always #5 clk = ~clk;

  vid_seq_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEW_WIDTH(2), .VL_WIDTH(VLW)) bus ();

  vid_seq_gen #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .SEW_WIDTH     (2),
    .VL_WIDTH      (VLW),
    .ENABLE_64_BIT (EN64),
    .OUT_STAGES    (STAGES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: B = ceil((vl-start)/E) beats, element k of beat b is index
  // start+b*E+k, kept only when below vl.
  task automatic model_push(input int sew, input int start, input int vl, input int addr,
                            input logic [63:0] base, input logic [63:0] stride);
    int          w, e, nb, idx;
    logic [63:0] v, m;
    beat_t       bt;
    if (sew == 3 && !EN64) return;
    if (start >= vl) return;
    w  = 8 << sew;
    e  = DW / w;
    nb = (vl - start + e - 1) / e;
    m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    for (int b = 0; b < nb; b++) begin
      bt      = '0;
      bt.addr = 5'((addr + b) % 32);
      bt.last = (b == nb - 1);
      for (int k = 0; k < e; k++) begin
        idx = start + b * e + k;
        if (idx < vl) begin
          v = (base + 64'(idx) * stride) & m;
          bt.vec = bt.vec | (v << (k * w));
          bt.be  = bt.be | 8'(((1 << (w / 8)) - 1) << (k * w / 8));
        end
      end
      exp_q.push_back(bt);
    end
  endtask

  // Returns at the negedge following the accept edge.
  task automatic issue(input int sew, input int start, input int vl, input int addr,
                       input logic [63:0] base, input logic [63:0] stride, input bit use_model);
    int n;
    bit legal;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL req_wait: in_ready %0b after %0d cycles, required 1", bus.in_ready, n);
      return;
    end
    bus.in_valid     = 1'b1;
    bus.in_sew       = 2'(sew);
    bus.in_start_idx = VLW'(start);
    bus.in_vl        = VLW'(vl);
    bus.in_addr      = AW'(addr);
`ifdef VID_STRIDE_EN
    bus.in_base      = base;
    bus.in_stride    = stride;
    if (use_model) model_push(sew, start, vl, addr, base, stride);
`else
    if (use_model) model_push(sew, start, vl, addr, 64'd0, 64'd1);
`endif
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    legal = !(sew == 3 && !EN64);
    chk("err_sew_pulse", 128'(bus.err_sew), 128'(!legal));
    chk("in_ready_after_accept", 128'(bus.in_ready), 128'(!(legal && start < vl)));
    if (!legal) begin
      @(negedge clk);
      chk("err_sew_single", 128'(bus.err_sew), 128'(0));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_remaining_beats", 128'(exp_q.size()), 128'(0));
  endtask

  // Monitor: compare each accepted beat against the scoreboard; while stalled,
  // the presented beat must not change.
  always @(negedge clk) begin
    beat_t cur, e;
    cur = '{vec: bus.out_vec, be: bus.out_be, addr: bus.out_addr, last: bus.out_last};
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("stall_hold", {cur, bus.out_valid}, {held, 1'b1});
      end
      held_v = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got %h, none expected", cur);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              errors++;
              $display("FAIL beat: got %h required %h", cur, e);
            end
          end
        end else begin
          held_v = 1'b1;
          held   = cur;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sew, start, vl, addr;
    logic [63:0] base, stride;
    bus.in_valid     = 1'b0;
    bus.in_sew       = '0;
    bus.in_start_idx = '0;
    bus.in_vl        = '0;
    bus.in_addr      = '0;
`ifdef VID_STRIDE_EN
    bus.in_base      = '0;
    bus.in_stride    = '0;
`endif
    bus.out_ready    = 1'b1;

    #12;
    chk("reset_in_ready", 128'(bus.in_ready), 128'(1));
    chk("reset_outputs", {bus.out_valid, bus.out_vec, bus.out_be, bus.out_addr, bus.out_last, bus.err_sew}, 128'(0));
    rst = 1'b0;

    // Single beat, latency OUT_STAGES after the accept edge.
    exp_q.push_back('{vec: 64'h0706050403020100, be: 8'hFF, addr: 5'd3, last: 1'b1});
    issue(0, 0, 8, 3, 64'd0, 64'd1, 1'b0);
    for (int i = 1; i <= STAGES; i++) begin
      @(negedge clk);
      chk("first_beat_latency", 128'(bus.out_valid), 128'(i == STAGES));
      chk("in_ready_after_single", 128'(bus.in_ready), 128'(1));
    end
    drain();

    // Two beats with tail masking and address wrap.
    exp_q.push_back('{vec: 64'h0005000400030002, be: 8'hFF, addr: 5'd31, last: 1'b0});
    exp_q.push_back('{vec: 64'h0000000000000006, be: 8'h03, addr: 5'd0,  last: 1'b1});
    issue(1, 2, 7, 31, 64'd0, 64'd1, 1'b0);
    drain();

    // Eight beats with a three-cycle stall in the middle.
    issue(0, 0, 64, 5, 64'd0, 64'd1, 1'b1);
    repeat (4) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain();

    // Empty request and illegal SEW: accepted, no beats.
    issue(0, 10, 10, 0, 64'd0, 64'd1, 1'b1);
    issue(3, 0, 8, 0, 64'd0, 64'd1, 1'b1);
    repeat (6) @(negedge clk);
    chk("no_beats_pending", 128'(exp_q.size()), 128'(0));

    // Asynchronous reset while beat 2 of 4 is presented.
    issue(0, 0, 32, 9, 64'd0, 64'd1, 1'b1);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {bus.out_valid, bus.out_vec, bus.out_be, bus.out_addr, bus.out_last, bus.err_sew}, 128'(0));
    chk("async_rst_in_ready", 128'(bus.in_ready), 128'(1));
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    issue(2, 1, 5, 7, 64'd0, 64'd1, 1'b1);
    drain();

`ifdef VID_STRIDE_EN
    exp_q.push_back('{vec: 64'h0000010400000100, be: 8'hFF, addr: 5'd0, last: 1'b1});
    issue(2, 0, 2, 0, 64'h100, 64'd4, 1'b0);
    drain();
`endif

    // Randomized requests with random backpressure.
    rand_ready = 1'b1;
    for (int r = 0; r < 40; r++) begin
      sew    = int'($urandom_range(0, 3));
      start  = int'($urandom_range(0, 100));
      vl     = int'($urandom_range(0, 200));
      addr   = int'($urandom_range(0, 31));
      base   = {$urandom(), $urandom()};
      stride = 64'($urandom_range(0, 300));
      issue(sew, start, vl, addr, base, stride, 1'b1);
    end
    drain();
    rand_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
